// File: rtl/relogio_cron_param.sv
// Time-of-day clock (hh:mm:ss) plus independent stopwatch (mm:ss:cc) with a 4-state mode FSM.
// Latency: button actions land on the clock edge that samples the press; display is combinational from registers.
// Backpressure: none; buttons are level inputs, edge-detected once per press, and holding a button has no further effect.
//
// Ports:
//   clk               system clock
//   rst               asynchronous active-low reset
//   modo, mais, menos level buttons synchronous to clk (mode, plus/start-stop, minus/clear/lap)
//   h, m, s           display fields (clock hh/mm/ss, or stopwatch mm/ss/cc in mode 1)
//   mode              current FSM state code
//   run, lap          stopwatch running / stopwatch display frozen
module relogio_cron_param #(
  parameter int TICK_DIV    = 500000,
  parameter int HOUR_MOD    = 24,
  parameter int CHR_MIN_MOD = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       modo,
  input  logic       mais,
  input  logic       menos,
  output logic [6:0] h,
  output logic [6:0] m,
  output logic [6:0] s,
  output logic [1:0] mode,
  output logic       run,
  output logic       lap
);

  localparam int         PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [6:0] HOUR_LAST = 7'(HOUR_MOD - 1);
  localparam logic [6:0] CMIN_LAST = 7'(CHR_MIN_MOD - 1);

  typedef enum logic [1:0] {
    CLK_SHOW = 2'd0,
    CHR_SHOW = 2'd1,
    SET_HOUR = 2'd2,
    SET_MIN  = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic            tick;

  logic            modo_q, mais_q, menos_q;
  logic            modo_p, mais_a, menos_a;

  logic [6:0]      c_cc, c_sec, c_min, c_hour;
  logic [6:0]      w_cc, w_sec, w_min;
  logic [6:0]      l_cc, l_sec, l_min;

  logic            clk_adv, sw_adv;

  // Prescaler and button history. The prescaler never stops, so tick phase
  // is a pure function of the time since reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= '0;
      modo_q  <= 1'b0;
      mais_q  <= 1'b0;
      menos_q <= 1'b0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      modo_q  <= modo;
      mais_q  <= mais;
      menos_q <= menos;
    end
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  // A modo press owns its cycle: mais/menos presses landing on the same edge are dropped.
  assign modo_p  = modo  & ~modo_q;
  assign mais_a  = mais  & ~mais_q  & ~modo_p;
  assign menos_a = menos & ~menos_q & ~modo_p;

  assign clk_adv = tick && ((state == CLK_SHOW) || (state == CHR_SHOW));
  assign sw_adv  = tick && run;

  // Time-of-day chain. Button adjustments come after the chain update so they
  // win for the fields they write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_cc   <= '0;
      c_sec  <= '0;
      c_min  <= '0;
      c_hour <= '0;
    end else begin
      if (clk_adv) begin
        c_cc <= (c_cc == 7'd99) ? 7'd0 : c_cc + 7'd1;
        if (c_cc == 7'd99) begin
          c_sec <= (c_sec == 7'd59) ? 7'd0 : c_sec + 7'd1;
          if (c_sec == 7'd59) begin
            c_min <= (c_min == 7'd59) ? 7'd0 : c_min + 7'd1;
            if (c_min == 7'd59)
              c_hour <= (c_hour == HOUR_LAST) ? 7'd0 : c_hour + 7'd1;
          end
        end
      end

      if (state == SET_HOUR) begin
        if (mais_a)
          c_hour <= (c_hour == HOUR_LAST) ? 7'd0 : c_hour + 7'd1;
        else if (menos_a)
          c_hour <= (c_hour == 7'd0) ? HOUR_LAST : c_hour - 7'd1;
      end

      // Minute adjust never carries into hours; it restarts the current minute.
      if ((state == SET_MIN) && (mais_a || menos_a)) begin
        if (mais_a)
          c_min <= (c_min == 7'd59) ? 7'd0 : c_min + 7'd1;
        else
          c_min <= (c_min == 7'd0) ? 7'd59 : c_min - 7'd1;
        c_sec <= 7'd0;
        c_cc  <= 7'd0;
      end
    end
  end

  // Mode FSM, stopwatch chain, run/lap control and lap capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLK_SHOW;
      run   <= 1'b0;
      lap   <= 1'b0;
      w_cc  <= '0;
      w_sec <= '0;
      w_min <= '0;
      l_cc  <= '0;
      l_sec <= '0;
      l_min <= '0;
    end else begin
      if (modo_p) begin
        case (state)
          CLK_SHOW: state <= CHR_SHOW;
          CHR_SHOW: state <= SET_HOUR;
          SET_HOUR: state <= SET_MIN;
          default:  state <= CLK_SHOW;
        endcase
      end

      if (sw_adv) begin
        w_cc <= (w_cc == 7'd99) ? 7'd0 : w_cc + 7'd1;
        if (w_cc == 7'd99) begin
          w_sec <= (w_sec == 7'd59) ? 7'd0 : w_sec + 7'd1;
          if (w_sec == 7'd59)
            w_min <= (w_min == CMIN_LAST) ? 7'd0 : w_min + 7'd1;
        end
      end

      if (state == CHR_SHOW) begin
        if (mais_a)
          run <= ~run;
        if (menos_a) begin
          if (run) begin
            lap <= ~lap;
            // Entering lap hold: snapshot the value shown just before this edge.
            if (!lap) begin
              l_cc  <= w_cc;
              l_sec <= w_sec;
              l_min <= w_min;
            end
          end else begin
            // Stopped: menos is a clear. The stopwatch cannot tick here, so no conflict.
            w_cc  <= 7'd0;
            w_sec <= 7'd0;
            w_min <= 7'd0;
            lap   <= 1'b0;
          end
        end
      end
    end
  end

  assign mode = state;

  always_comb begin
    h = c_hour;
    m = c_min;
    s = c_sec;
    if (state == CHR_SHOW) begin
      if (lap) begin
        h = l_min;
        m = l_sec;
        s = l_cc;
      end else begin
        h = w_min;
        m = w_sec;
        s = w_cc;
      end
    end
  end

endmodule

// File: tb/tb_relogio_cron_param.sv
module tb_relogio_cron_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       modo = 1'b0, mais = 1'b0, menos = 1'b0;
  logic       modo2 = 1'b0, mais2 = 1'b0, menos2 = 1'b0;
  logic [6:0] h, m, s, h2, m2, s2;
  logic [1:0] mode, mode2;
  logic       run, lap, run2, lap2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  relogio_cron_param #(.TICK_DIV(2), .HOUR_MOD(24), .CHR_MIN_MOD(100)) dut (
    .clk(clk), .rst(rst), .modo(modo), .mais(mais), .menos(menos),
    .h(h), .m(m), .s(s), .mode(mode), .run(run), .lap(lap)
  );

  // Second instance: 12-hour clock and a one-minute stopwatch so the stopwatch
  // full wrap is reachable in a short run.
  relogio_cron_param #(.TICK_DIV(2), .HOUR_MOD(12), .CHR_MIN_MOD(1)) dut2 (
    .clk(clk), .rst(rst), .modo(modo2), .mais(mais2), .menos(menos2),
    .h(h2), .m(m2), .s(s2), .mode(mode2), .run(run2), .lap(lap2)
  );

  // Button ids: 0 modo, 1 mais, 2 menos (dut); 3 modo, 4 mais, 5 menos (dut2).
  // The press lands on the next rising edge; one idle edge follows so that
  // consecutive presses of the same button are seen as separate presses.
  task automatic press(input int b);
    case (b)
      0: modo = 1'b1;
      1: mais = 1'b1;
      2: menos = 1'b1;
      3: modo2 = 1'b1;
      4: mais2 = 1'b1;
      default: menos2 = 1'b1;
    endcase
    @(posedge clk); #1;
    modo = 1'b0; mais = 1'b0; menos = 1'b0;
    modo2 = 1'b0; mais2 = 1'b0; menos2 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    modo = 1'b0; mais = 1'b0; menos = 1'b0;
    modo2 = 1'b0; mais2 = 1'b0; menos2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h, m, s, mode, run, lap} !== 25'd0) begin
      failures++;
      $display("FAIL reset_state: got h=%0d m=%0d s=%0d mode=%0d run=%0d lap=%0d, want all 0", h, m, s, mode, run, lap);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (199) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h, m, s} !== {7'd0, 7'd0, 7'd0}) begin
      failures++;
      $display("FAIL run_99_ticks: got %0d:%0d:%0d, want 0:0:0", h, m, s);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h, m, s} !== {7'd0, 7'd0, 7'd1}) begin
      failures++;
      $display("FAIL run_100_ticks: got %0d:%0d:%0d, want 0:0:1", h, m, s);
    end
    press(0);
    press(1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mode, run} !== {2'd1, 1'b1}) begin
      failures++;
      $display("FAIL pre_async_state: got mode=%0d run=%0d, want mode=1 run=1", mode, run);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({h, m, s, mode, run, lap} !== 25'd0) begin
      failures++;
      $display("FAIL async_reset: got h=%0d m=%0d s=%0d mode=%0d run=%0d lap=%0d, want all 0", h, m, s, mode, run, lap);
    end
  endtask

  task automatic test_set_mode();
    do_reset();
    press(0);
    press(0);
    press(2);
    @(negedge clk);
    checks++;
    if ({mode, h} !== {2'd2, 7'd23}) begin
      failures++;
      $display("FAIL set_hour_dec: got mode=%0d h=%0d, want mode=2 h=23", mode, h);
    end
    press(0);
    press(1);
    @(negedge clk);
    checks++;
    if ({mode, h, m, s} !== {2'd3, 7'd23, 7'd1, 7'd0}) begin
      failures++;
      $display("FAIL set_min_inc: got mode=%0d %0d:%0d:%0d, want mode=3 23:1:0", mode, h, m, s);
    end
    repeat (250) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h, m, s} !== {7'd23, 7'd1, 7'd0}) begin
      failures++;
      $display("FAIL set_frozen: got %0d:%0d:%0d, want 23:1:0", h, m, s);
    end
    press(0);
    repeat (197) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mode, h, m, s} !== {2'd0, 7'd23, 7'd1, 7'd0}) begin
      failures++;
      $display("FAIL resume_99_ticks: got mode=%0d %0d:%0d:%0d, want mode=0 23:1:0", mode, h, m, s);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h, m, s} !== {7'd23, 7'd1, 7'd1}) begin
      failures++;
      $display("FAIL resume_100_ticks: got %0d:%0d:%0d, want 23:1:1", h, m, s);
    end
  endtask

  // Continues from test_set_mode: clock is at 23:01:01.
  task automatic test_clock_rollover();
    press(0);
    press(0);
    press(0);
    press(2);
    press(2);
    press(0);
    repeat (11799) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mode, h, m, s} !== {2'd0, 7'd23, 7'd59, 7'd59}) begin
      failures++;
      $display("FAIL roll24_pre: got mode=%0d %0d:%0d:%0d, want mode=0 23:59:59", mode, h, m, s);
    end
    repeat (198) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h, m, s} !== {7'd23, 7'd59, 7'd59}) begin
      failures++;
      $display("FAIL roll24_last: got %0d:%0d:%0d, want 23:59:59", h, m, s);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h, m, s} !== {7'd0, 7'd0, 7'd0}) begin
      failures++;
      $display("FAIL roll24_wrap: got %0d:%0d:%0d, want 0:0:0", h, m, s);
    end
  endtask

  task automatic test_rollover12();
    do_reset();
    press(3);
    press(3);
    press(5);
    @(negedge clk);
    checks++;
    if ({mode2, h2} !== {2'd2, 7'd11}) begin
      failures++;
      $display("FAIL set_hour12_dec: got mode=%0d h=%0d, want mode=2 h=11", mode2, h2);
    end
    press(3);
    press(5);
    press(3);
    repeat (11799) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mode2, h2, m2, s2} !== {2'd0, 7'd11, 7'd59, 7'd59}) begin
      failures++;
      $display("FAIL roll12_pre: got mode=%0d %0d:%0d:%0d, want mode=0 11:59:59", mode2, h2, m2, s2);
    end
    repeat (200) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h2, m2, s2} !== {7'd0, 7'd0, 7'd0}) begin
      failures++;
      $display("FAIL roll12_wrap: got %0d:%0d:%0d, want 0:0:0", h2, m2, s2);
    end
  endtask

  task automatic test_stopwatch();
    do_reset();
    press(0);
    press(1);
    repeat (299) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mode, run, h, m, s} !== {2'd1, 1'b1, 7'd0, 7'd1, 7'd50}) begin
      failures++;
      $display("FAIL sw_150_ticks: got mode=%0d run=%0d %0d:%0d:%0d, want mode=1 run=1 0:1:50", mode, run, h, m, s);
    end
    press(2);
    @(negedge clk);
    checks++;
    if ({lap, h, m, s} !== {1'b1, 7'd0, 7'd1, 7'd50}) begin
      failures++;
      $display("FAIL lap_capture: got lap=%0d %0d:%0d:%0d, want lap=1 0:1:50", lap, h, m, s);
    end
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({lap, run, h, m, s} !== {1'b1, 1'b1, 7'd0, 7'd1, 7'd50}) begin
      failures++;
      $display("FAIL lap_hold: got lap=%0d run=%0d %0d:%0d:%0d, want lap=1 run=1 0:1:50", lap, run, h, m, s);
    end
    press(2);
    @(negedge clk);
    checks++;
    if ({lap, h, m} !== {1'b0, 7'd0, 7'd2}) begin
      failures++;
      $display("FAIL lap_release: got lap=%0d %0d:%0d, want lap=0 0:2", lap, h, m);
    end
    press(1);
    @(negedge clk);
    checks++;
    if (run !== 1'b0) begin
      failures++;
      $display("FAIL sw_stop: got run=%0d, want 0", run);
    end
    press(2);
    @(negedge clk);
    checks++;
    if ({run, lap, h, m, s} !== {1'b0, 1'b0, 7'd0, 7'd0, 7'd0}) begin
      failures++;
      $display("FAIL sw_clear: got run=%0d lap=%0d %0d:%0d:%0d, want run=0 lap=0 0:0:0", run, lap, h, m, s);
    end
  endtask

  // Continues from test_stopwatch: mode 1, stopwatch stopped.
  task automatic test_back_to_back();
    modo = 1'b1;
    mais = 1'b1;
    @(posedge clk); #1;
    modo = 1'b0;
    mais = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mode, run} !== {2'd2, 1'b0}) begin
      failures++;
      $display("FAIL modo_precedence: got mode=%0d run=%0d, want mode=2 run=0", mode, run);
    end
    #1;
    press(0);
    press(0);
    press(0);
    mais = 1'b1;
    repeat (20) @(posedge clk);
    #1 mais = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mode, run} !== {2'd1, 1'b1}) begin
      failures++;
      $display("FAIL hold_single_toggle: got mode=%0d run=%0d, want mode=1 run=1", mode, run);
    end
  endtask

  task automatic test_sw_wrap();
    do_reset();
    press(3);
    press(4);
    repeat (11799) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({run2, h2, m2, s2} !== {1'b1, 7'd0, 7'd59, 7'd0}) begin
      failures++;
      $display("FAIL sw_wrap_pre: got run=%0d %0d:%0d:%0d, want run=1 0:59:0", run2, h2, m2, s2);
    end
    repeat (198) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h2, m2, s2} !== {7'd0, 7'd59, 7'd99}) begin
      failures++;
      $display("FAIL sw_wrap_last: got %0d:%0d:%0d, want 0:59:99", h2, m2, s2);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({run2, h2, m2, s2} !== {1'b1, 7'd0, 7'd0, 7'd0}) begin
      failures++;
      $display("FAIL sw_wrap: got run=%0d %0d:%0d:%0d, want run=1 0:0:0", run2, h2, m2, s2);
    end
  endtask

  initial begin
    test_reset();
    test_set_mode();
    test_clock_rollover();
    test_stopwatch();
    test_back_to_back();
    test_rollover12();
    test_sw_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
